// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low segment
// codes {dp,g,f,e,d,c,b,a}, digit count and scan FSM state encoding.
package smg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/smg_encode_module.sv
// Combinational BCD to active-low seven-segment lookup (dp excluded).
// valid_o is low for non-decimal codes so the caller can also blank the dp.
module smg_encode_module
    import smg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o,
    output logic       valid_o
);

    // Segment pattern per decimal digit; codes 10-15 blank the digit
    always_comb begin
        seg_o   = SEG_OFF[6:0];
        valid_o = 1'b1;
        case (bcd_i)
            4'd0:    seg_o = SEG_0[6:0];
            4'd1:    seg_o = SEG_1[6:0];
            4'd2:    seg_o = SEG_2[6:0];
            4'd3:    seg_o = SEG_3[6:0];
            4'd4:    seg_o = SEG_4[6:0];
            4'd5:    seg_o = SEG_5[6:0];
            4'd6:    seg_o = SEG_6[6:0];
            4'd7:    seg_o = SEG_7[6:0];
            4'd8:    seg_o = SEG_8[6:0];
            4'd9:    seg_o = SEG_9[6:0];
            default: begin
                seg_o   = SEG_OFF[6:0];
                valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/smg_scan_ctrl_module.sv
// Six-digit multiplexed seven-segment scanner with guard gaps, per-digit blink
// and frame-aligned digit loading through a req/ack handshake.
module smg_scan_ctrl_module
    import smg_pkg::*;
#(
    parameter int         SCAN_DIV     = 50000,
    parameter int         GUARD_CYC    = 500,
    parameter int         BLINK_FRAMES = 83,
    parameter logic [5:0] DP_MASK      = 6'b010100
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] One_Data0,
    input  logic [3:0] Ten_Data0,
    input  logic [3:0] One_Data1,
    input  logic [3:0] Ten_Data1,
    input  logic [3:0] One_Data2,
    input  logic [3:0] Ten_Data2,
    input  logic       Update_Req,
    input  logic [5:0] Blink_Mask,
    output logic [7:0] SMG_Data,
    output logic [5:0] Scan_Sig,
    output logic       Update_Ack,
    output logic       Frame_Done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD_CYC);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]              presc_q, presc_d;
    logic [2:0]                 idx_q, idx_d;
    scan_state_e                state_q, state_d;
    logic [FW-1:0]              frm_q, frm_d;
    logic                       phase_q, phase_d;
    logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [7:0]                 smg_q, smg_d;
    logic [NUM_DIGITS-1:0]      scan_q, scan_d;
    logic                       ack_q, ack_d;
    logic                       done_q, done_d;
    logic                       tick_s, frame_end_s;
    logic [3:0]                 digit_s;
    logic [6:0]                 seg_s;
    logic                       seg_valid_s;

    assign digit_s = shadow_q[idx_q];

    smg_encode_module u_encode (
        .bcd_i   (digit_s),
        .seg_o   (seg_s),
        .valid_o (seg_valid_s)
    );

    // Slot timing, frame/blink bookkeeping and frame-boundary digit capture
    always_comb begin
        presc_d     = presc_q;
        idx_d       = idx_q;
        frm_d       = frm_q;
        phase_d     = phase_q;
        shadow_d    = shadow_q;
        ack_d       = 1'b0;
        tick_s      = (presc_q == PRESC_LAST);
        frame_end_s = tick_s && (idx_q == IDX_LAST);
        done_d      = frame_end_s;

        if (tick_s) begin
            presc_d = {PW{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end

        // State tracks the prescaler value it will sit beside next cycle
        if (presc_d < GUARD_END) begin
            state_d = GUARD;
        end else begin
            state_d = SHOW;
        end

        if (frame_end_s) begin
            if (frm_q == FRAME_LAST) begin
                frm_d   = {FW{1'b0}};
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
            if (Update_Req) begin
                shadow_d = {Ten_Data2, One_Data2, Ten_Data1, One_Data1, Ten_Data0, One_Data0};
                ack_d    = 1'b1;
            end else begin
                ack_d = 1'b0;
            end
        end else begin
            ack_d = 1'b0;
        end
    end

    // Next output pattern; invalid digits blank the dp as well
    always_comb begin
        scan_d = {NUM_DIGITS{1'b1}};
        smg_d  = SEG_OFF;
        case (state_q)
            SHOW: begin
                scan_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
                if (phase_q && Blink_Mask[idx_q]) begin
                    smg_d = SEG_OFF;
                end else begin
                    smg_d = {~(seg_valid_s && DP_MASK[idx_q]), seg_s};
                end
            end
            default: begin
                scan_d = {NUM_DIGITS{1'b1}};
                smg_d  = SEG_OFF;
            end
        endcase
    end

    // Scan FSM state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= GUARD;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered output stage
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_q  <= {PW{1'b0}};
            idx_q    <= 3'd0;
            frm_q    <= {FW{1'b0}};
            phase_q  <= 1'b0;
            shadow_q <= {NUM_DIGITS{4'hF}};
            smg_q    <= SEG_OFF;
            scan_q   <= {NUM_DIGITS{1'b1}};
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            frm_q    <= frm_d;
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            smg_q    <= smg_d;
            scan_q   <= scan_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
        end
    end

    assign SMG_Data   = smg_q;
    assign Scan_Sig   = scan_q;
    assign Update_Ack = ack_q;
    assign Frame_Done = done_q;

endmodule

// File: tb/tb_smg_scan_ctrl_module.sv
// Directed bench for smg_scan_ctrl_module with SCAN_DIV=8, GUARD_CYC=2, BLINK_FRAMES=2.
// t counts rising edges since reset release; slot s of frame f is sampled at t=48f+8s+4.
module tb_smg_scan_ctrl_module;

    logic       CLK;
    logic       RSTn;
    logic [3:0] One_Data0, Ten_Data0, One_Data1, Ten_Data1, One_Data2, Ten_Data2;
    logic       Update_Req;
    logic [5:0] Blink_Mask;
    logic [7:0] SMG_Data;
    logic [5:0] Scan_Sig;
    logic       Update_Ack;
    logic       Frame_Done;

    int vectors;
    int miscompares;
    int t;

    smg_scan_ctrl_module #(
        .SCAN_DIV     (8),
        .GUARD_CYC    (2),
        .BLINK_FRAMES (2),
        .DP_MASK      (6'b010100)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .One_Data0  (One_Data0),
        .Ten_Data0  (Ten_Data0),
        .One_Data1  (One_Data1),
        .Ten_Data1  (Ten_Data1),
        .One_Data2  (One_Data2),
        .Ten_Data2  (Ten_Data2),
        .Update_Req (Update_Req),
        .Blink_Mask (Blink_Mask),
        .SMG_Data   (SMG_Data),
        .Scan_Sig   (Scan_Sig),
        .Update_Ack (Update_Ack),
        .Frame_Done (Frame_Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic go_to(input int target);
        while (t < target) begin
            @(negedge CLK);
            t++;
        end
    endtask

    task automatic do_reset();
        RSTn       = 1'b0;
        Update_Req = 1'b0;
        Blink_Mask = 6'b000000;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        t    = 0;
    endtask

    task automatic set_digits(input logic [3:0] d5, input logic [3:0] d4, input logic [3:0] d3,
                              input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        Ten_Data2 = d5; One_Data2 = d4; Ten_Data1 = d3;
        One_Data1 = d2; Ten_Data0 = d1; One_Data0 = d0;
    endtask

    task automatic test_reset();
        RSTn       = 1'b0;
        Update_Req = 1'b0;
        Blink_Mask = 6'b000000;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge CLK);
        vectors++; if (SMG_Data !== 8'hFF) begin miscompares++; $display("FAIL reset_smg got=%h exp=ff", SMG_Data); end
        vectors++; if (Scan_Sig !== 6'h3F) begin miscompares++; $display("FAIL reset_scan got=%h exp=3f", Scan_Sig); end
        vectors++; if (Update_Ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b exp=0", Update_Ack); end
        vectors++; if (Frame_Done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", Frame_Done); end
    endtask

    task automatic test_walk();
        logic [5:0] walk [6];
        walk = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            go_to(8 * s + 2);
            vectors++; if (Scan_Sig !== 6'h3F) begin miscompares++; $display("FAIL walk_guard s%0d got=%h exp=3f", s, Scan_Sig); end
            go_to(8 * s + 4);
            vectors++; if (Scan_Sig !== walk[s]) begin miscompares++; $display("FAIL walk_scan s%0d got=%h exp=%h", s, Scan_Sig, walk[s]); end
            vectors++; if (SMG_Data !== 8'hFF) begin miscompares++; $display("FAIL walk_smg s%0d got=%h exp=ff", s, SMG_Data); end
        end
        go_to(47);
        vectors++; if (Frame_Done !== 1'b0) begin miscompares++; $display("FAIL walk_done_early got=%b exp=0", Frame_Done); end
        go_to(48);
        vectors++; if (Frame_Done !== 1'b1) begin miscompares++; $display("FAIL walk_done got=%b exp=1", Frame_Done); end
        vectors++; if (Update_Ack !== 1'b0) begin miscompares++; $display("FAIL walk_noack got=%b exp=0", Update_Ack); end
    endtask

    task automatic test_load();
        logic [7:0] exp [6];
        exp = '{8'h90, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9};
        do_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9);
        Update_Req = 1'b1;
        go_to(47);
        vectors++; if (Update_Ack !== 1'b0) begin miscompares++; $display("FAIL load_ack_early got=%b exp=0", Update_Ack); end
        go_to(48);
        vectors++; if (Update_Ack !== 1'b1) begin miscompares++; $display("FAIL load_ack got=%b exp=1", Update_Ack); end
        vectors++; if (Frame_Done !== 1'b1) begin miscompares++; $display("FAIL load_done got=%b exp=1", Frame_Done); end
        go_to(49);
        vectors++; if (Update_Ack !== 1'b0) begin miscompares++; $display("FAIL load_ack_pulse got=%b exp=0", Update_Ack); end
        for (int s = 0; s < 6; s++) begin
            go_to(48 + 8 * s + 4);
            vectors++; if (SMG_Data !== exp[s]) begin miscompares++; $display("FAIL load_smg s%0d got=%h exp=%h", s, SMG_Data, exp[s]); end
        end
        go_to(96);
        vectors++; if (Update_Ack !== 1'b1) begin miscompares++; $display("FAIL load_ack_frame2 got=%b exp=1", Update_Ack); end
        Update_Req = 1'b0;
    endtask

    task automatic test_req_dropped();
        do_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9);
        Update_Req = 1'b1;
        go_to(50);
        Update_Req = 1'b0;
        go_to(60);
        set_digits(4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8);
        Update_Req = 1'b1;
        go_to(70);
        Update_Req = 1'b0;
        go_to(96);
        vectors++; if (Frame_Done !== 1'b1) begin miscompares++; $display("FAIL drop_done got=%b exp=1", Frame_Done); end
        vectors++; if (Update_Ack !== 1'b0) begin miscompares++; $display("FAIL drop_noack got=%b exp=0", Update_Ack); end
        go_to(100);
        vectors++; if (SMG_Data !== 8'h90) begin miscompares++; $display("FAIL drop_pos0 got=%h exp=90", SMG_Data); end
        go_to(116);
        vectors++; if (SMG_Data !== 8'h19) begin miscompares++; $display("FAIL drop_pos2 got=%h exp=19", SMG_Data); end
        go_to(124);
        vectors++; if (SMG_Data !== 8'hB0) begin miscompares++; $display("FAIL drop_pos3 got=%h exp=b0", SMG_Data); end
    endtask

    task automatic test_invalid_digit();
        do_reset();
        set_digits(4'd0, 4'd0, 4'hC, 4'd7, 4'd6, 4'd8);
        Update_Req = 1'b1;
        go_to(50);
        Update_Req = 1'b0;
        go_to(52);
        vectors++; if (SMG_Data !== 8'h80) begin miscompares++; $display("FAIL inv_pos0 got=%h exp=80", SMG_Data); end
        go_to(60);
        vectors++; if (SMG_Data !== 8'h82) begin miscompares++; $display("FAIL inv_pos1 got=%h exp=82", SMG_Data); end
        go_to(68);
        vectors++; if (SMG_Data !== 8'h78) begin miscompares++; $display("FAIL inv_pos2 got=%h exp=78", SMG_Data); end
        go_to(76);
        vectors++; if (SMG_Data !== 8'hFF) begin miscompares++; $display("FAIL inv_pos3 got=%h exp=ff", SMG_Data); end
        vectors++; if (Scan_Sig !== 6'h37) begin miscompares++; $display("FAIL inv_scan3 got=%h exp=37", Scan_Sig); end
        go_to(84);
        vectors++; if (SMG_Data !== 8'h40) begin miscompares++; $display("FAIL inv_pos4 got=%h exp=40", SMG_Data); end
        go_to(92);
        vectors++; if (SMG_Data !== 8'hC0) begin miscompares++; $display("FAIL inv_pos5 got=%h exp=c0", SMG_Data); end
    endtask

    task automatic test_blink();
        logic [7:0] exp0 [6];
        exp0 = '{8'h00, 8'h90, 8'hFF, 8'hFF, 8'h90, 8'h90};
        do_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9);
        Update_Req = 1'b1;
        go_to(50);
        Update_Req = 1'b0;
        Blink_Mask = 6'b000001;
        for (int f = 1; f < 6; f++) begin
            go_to(48 * f + 4);
            vectors++; if (SMG_Data !== exp0[f]) begin miscompares++; $display("FAIL blink_pos0 f%0d got=%h exp=%h", f, SMG_Data, exp0[f]); end
            vectors++; if (Scan_Sig !== 6'h3E) begin miscompares++; $display("FAIL blink_scan0 f%0d got=%h exp=3e", f, Scan_Sig); end
            go_to(48 * f + 12);
            vectors++; if (SMG_Data !== 8'h92) begin miscompares++; $display("FAIL blink_pos1 f%0d got=%h exp=92", f, SMG_Data); end
        end
        Blink_Mask = 6'b000000;
    endtask

    task automatic test_async_reset();
        do_reset();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9);
        Update_Req = 1'b1;
        go_to(50);
        Update_Req = 1'b0;
        go_to(76);
        vectors++; if (Scan_Sig !== 6'h37) begin miscompares++; $display("FAIL arst_pre_scan got=%h exp=37", Scan_Sig); end
        RSTn = 1'b0;
        #1;
        vectors++; if (Scan_Sig !== 6'h3F) begin miscompares++; $display("FAIL arst_scan got=%h exp=3f", Scan_Sig); end
        vectors++; if (SMG_Data !== 8'hFF) begin miscompares++; $display("FAIL arst_smg got=%h exp=ff", SMG_Data); end
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        t    = 0;
        go_to(2);
        vectors++; if (Scan_Sig !== 6'h3F) begin miscompares++; $display("FAIL arst_guard got=%h exp=3f", Scan_Sig); end
        go_to(3);
        vectors++; if (Scan_Sig !== 6'h3E) begin miscompares++; $display("FAIL arst_first_show got=%h exp=3e", Scan_Sig); end
        vectors++; if (SMG_Data !== 8'hFF) begin miscompares++; $display("FAIL arst_shadow got=%h exp=ff", SMG_Data); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        t           = 0;
        test_reset();
        test_walk();
        test_load();
        test_req_dropped();
        test_invalid_digit();
        test_blink();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
